// File: rtl/reg_access_unit.sv
// reg_access_unit: RV32I general-purpose register file with multi-port
// combinational reads and optional write forwarding, a machine-mode CSR bank
// driven by a three-state read-modify-write engine, and free-running 64-bit
// mcycle/minstret counters.
module reg_access_unit #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int CSR_AW = 12,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                halt,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                csr_valid,
  input  logic [2:0]          csr_funct3,
  input  logic [CSR_AW-1:0]   csr_addr,
  input  logic [XLEN-1:0]     csr_src,
  input  logic [4:0]          csr_uimm,
  output logic [XLEN-1:0]     csr_rdata,
  output logic                csr_done,
  output logic                csr_illegal,
  input  logic                retire
);

  localparam logic [CSR_AW-1:0] ADDR_MSTATUS   = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] ADDR_MTVEC     = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] ADDR_MSCRATCH  = CSR_AW'(12'h340);
  localparam logic [CSR_AW-1:0] ADDR_MEPC      = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] ADDR_MCAUSE    = CSR_AW'(12'h342);
  localparam logic [CSR_AW-1:0] ADDR_MCYCLE    = CSR_AW'(12'hB00);
  localparam logic [CSR_AW-1:0] ADDR_MCYCLEH   = CSR_AW'(12'hB80);
  localparam logic [CSR_AW-1:0] ADDR_MINSTRET  = CSR_AW'(12'hB02);
  localparam logic [CSR_AW-1:0] ADDR_MINSTRETH = CSR_AW'(12'hB82);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RMW  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  logic [XLEN-1:0] gpr_q [NREG];
  logic            gpr_we;

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [63:0]     mcycle_q, mcycle_d;
  logic [63:0]     minstret_q, minstret_d;

  state_e          state_q, state_d;
  logic [XLEN-1:0] csr_rdata_q, csr_rdata_d;
  logic            csr_done_q, csr_done_d;
  logic            csr_illegal_q, csr_illegal_d;

  logic [XLEN-1:0] csr_old, csr_op, csr_new;
  logic            csr_addr_ok, csr_bad, csr_we;

  // A write that lands on x0 or happens while frozen is dropped entirely.
  assign gpr_we = wr_en & ~halt & (wr_addr != '0);

  // GPR storage; x0 is never written so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register array is reset explicitly because software relies on
      // every GPR reading zero after reset; state elements always use <= so all
      // flops sample their inputs from the same pre-edge values.
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
    end else if (gpr_we) begin
      gpr_q[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] word;

    assign addr = rd_addr[k*AW +: AW];

    // One read port: x0 reads zero, a same-cycle write is forwarded if enabled.
    always_comb begin
      if (addr == '0) begin
        word = '0;
      end else if ((BYPASS != 0) && gpr_we && (wr_addr == addr)) begin
        word = wr_data;
      end else begin
        word = gpr_q[addr];
      end
    end

    assign rd_data[k*XLEN +: XLEN] = word;
  end

  // CSR decode: old value, operand and candidate new value of the request.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements leaves a variable unassigned (a latch).
    csr_addr_ok = 1'b1;
    csr_old     = '0;
    case (csr_addr)
      ADDR_MSTATUS:   csr_old = mstatus_q;
      ADDR_MTVEC:     csr_old = mtvec_q;
      ADDR_MSCRATCH:  csr_old = mscratch_q;
      ADDR_MEPC:      csr_old = mepc_q;
      ADDR_MCAUSE:    csr_old = mcause_q;
      ADDR_MCYCLE:    csr_old = XLEN'(mcycle_q[31:0]);
      ADDR_MCYCLEH:   csr_old = XLEN'(mcycle_q[63:32]);
      ADDR_MINSTRET:  csr_old = XLEN'(minstret_q[31:0]);
      ADDR_MINSTRETH: csr_old = XLEN'(minstret_q[63:32]);
      default:        csr_addr_ok = 1'b0;
    endcase

    csr_op = csr_funct3[2] ? XLEN'(csr_uimm) : csr_src;

    case (csr_funct3[1:0])
      2'b01:   csr_new = csr_op;
      2'b10:   csr_new = csr_old | csr_op;
      default: csr_new = csr_old & ~csr_op;
    endcase

    csr_bad = ~csr_addr_ok | (csr_funct3[1:0] == 2'b00);

    // Set/clear with a zero operand is a pure read and must not write.
    csr_we = (state_q == ST_RMW) && !halt && !csr_bad &&
             ((csr_funct3[1:0] == 2'b01) || (csr_op != '0));
  end

  // Next value of the plain machine-mode CSRs.
  always_comb begin
    mstatus_d  = mstatus_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (csr_we) begin
      case (csr_addr)
        ADDR_MSTATUS:  mstatus_d  = csr_new;
        ADDR_MTVEC:    mtvec_d    = {csr_new[XLEN-1:2], 2'b00};
        ADDR_MSCRATCH: mscratch_d = csr_new;
        ADDR_MEPC:     mepc_d     = {csr_new[XLEN-1:2], 2'b00};
        ADDR_MCAUSE:   mcause_d   = csr_new;
        default:       ;
      endcase
    end
  end

  // Counter next values: a CSR write to either half replaces that half and
  // suppresses the increment for that cycle; otherwise the 64-bit add carries.
  always_comb begin
    mcycle_d = mcycle_q;
    if (csr_we && (csr_addr == ADDR_MCYCLE)) begin
      mcycle_d[31:0] = csr_new[31:0];
    end else if (csr_we && (csr_addr == ADDR_MCYCLEH)) begin
      mcycle_d[63:32] = csr_new[31:0];
    end else if (!halt) begin
      mcycle_d = mcycle_q + 64'd1;
    end

    minstret_d = minstret_q;
    if (csr_we && (csr_addr == ADDR_MINSTRET)) begin
      minstret_d[31:0] = csr_new[31:0];
    end else if (csr_we && (csr_addr == ADDR_MINSTRETH)) begin
      minstret_d[63:32] = csr_new[31:0];
    end else if (!halt && retire) begin
      minstret_d = minstret_q + 64'd1;
    end
  end

  // CSR bank and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q  <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  // Request sequencing IDLE -> RMW -> DONE -> IDLE; halt freezes every state.
  always_comb begin
    state_d       = state_q;
    csr_rdata_d   = csr_rdata_q;
    csr_done_d    = csr_done_q;
    csr_illegal_d = csr_illegal_q;
    if (!halt) begin
      case (state_q)
        ST_IDLE: begin
          if (csr_valid) state_d = ST_RMW;
        end
        ST_RMW: begin
          state_d       = ST_DONE;
          csr_rdata_d   = csr_old;
          csr_done_d    = 1'b1;
          csr_illegal_d = csr_bad;
        end
        ST_DONE: begin
          state_d       = ST_IDLE;
          csr_rdata_d   = '0;
          csr_done_d    = 1'b0;
          csr_illegal_d = 1'b0;
        end
        default: begin
          state_d       = ST_IDLE;
          csr_rdata_d   = '0;
          csr_done_d    = 1'b0;
          csr_illegal_d = 1'b0;
        end
      endcase
    end
  end

  // FSM state and its registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      csr_rdata_q   <= '0;
      csr_done_q    <= 1'b0;
      csr_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      csr_rdata_q   <= csr_rdata_d;
      csr_done_q    <= csr_done_d;
      csr_illegal_q <= csr_illegal_d;
    end
  end

  // A completion held in DONE stays invisible while the unit is frozen.
  assign csr_done    = csr_done_q & ~halt;
  assign csr_rdata   = csr_rdata_q;
  assign csr_illegal = csr_illegal_q;

endmodule
